// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-requester arbiter and sequencer for a single-port data memory
// (8-bit x 128 by default). One request is accepted at a time; the winner's
// address, write-enable and write-data are registered onto the memory port.
// Reads wait RD_LAT cycles after the address is applied, then the memory
// output is captured into the owner's rdata register with a one-cycle rvalid.
//
// Arbitration:
//   default                 round-robin on ties; A wins the first tie after reset
//   DMEM_ARB_FIXED_PRI_EN   fixed priority: A always wins a tie, B can starve
//   Timing is identical in both modes.
//
// Parameters:
//   ADDR_W  memory address width
//   DATA_W  memory data width
//   RD_LAT  cycles from address applied to dataout valid, 1..7
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata   requester A request (held until a_gnt)
//   a_gnt                       one-cycle pulse, A's request accepted
//   a_rvalid/a_rdata            A read return; a_rdata held between reads
//   b_*                         same set for requester B
//   mem_address/mem_wren/mem_datain   to memory
//   mem_dataout                 from memory
//   busy                        high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout,

    output logic              busy
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StWait   = 2'd2
    } state_e;

    // WAIT lasts RD_LAT cycles: the counter starts at RD_LAT-1 and the
    // capture happens on the edge where it reads zero.
    localparam logic [2:0] CntInit = 3'(RD_LAT - 1);

    state_e            state_q, state_d;
    logic              last_b_q, last_b_d;    // 1: last grant went to B
    logic              owner_b_q, owner_b_d;  // owner of the access in flight
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic              mem_wren_q, mem_wren_d;
    logic [DATA_W-1:0] mem_datain_q, mem_datain_d;
    logic              a_gnt_q, a_gnt_d;
    logic              b_gnt_q, b_gnt_d;
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    logic pick_a;
    logic pick_b;

    // Winner selection; only acted upon while idle.
    always_comb begin
`ifdef DMEM_ARB_FIXED_PRI_EN
        pick_a = a_req;
`else
        pick_a = a_req & (~b_req | last_b_q);
`endif
        pick_b = b_req & ~pick_a;
    end

    always_comb begin
        state_d       = state_q;
        last_b_d      = last_b_q;
        owner_b_d     = owner_b_q;
        cnt_d         = cnt_q;
        mem_address_d = mem_address_q;
        mem_wren_d    = 1'b0;
        mem_datain_d  = mem_datain_q;
        a_gnt_d       = 1'b0;
        b_gnt_d       = 1'b0;
        a_rvalid_d    = 1'b0;
        b_rvalid_d    = 1'b0;
        a_rdata_d     = a_rdata_q;
        b_rdata_d     = b_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (pick_a) begin
                    mem_address_d = a_addr;
                    mem_wren_d    = a_we;
                    mem_datain_d  = a_wdata;
                    a_gnt_d       = 1'b1;
                    last_b_d      = 1'b0;
                    owner_b_d     = 1'b0;
                    state_d       = StAccess;
                end else if (pick_b) begin
                    mem_address_d = b_addr;
                    mem_wren_d    = b_we;
                    mem_datain_d  = b_wdata;
                    b_gnt_d       = 1'b1;
                    last_b_d      = 1'b1;
                    owner_b_d     = 1'b1;
                    state_d       = StAccess;
                end
            end

            StAccess: begin
                // mem_wren_q still carries the accepted request's direction.
                if (mem_wren_q) begin
                    state_d = StIdle;
                end else begin
                    cnt_d   = CntInit;
                    state_d = StWait;
                end
            end

            StWait: begin
                if (cnt_q == 3'd0) begin
                    if (owner_b_q) begin
                        b_rdata_d  = mem_dataout;
                        b_rvalid_d = 1'b1;
                    end else begin
                        a_rdata_d  = mem_dataout;
                        a_rvalid_d = 1'b1;
                    end
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            last_b_q      <= 1'b1;
            owner_b_q     <= 1'b0;
            cnt_q         <= 3'd0;
            mem_address_q <= '0;
            mem_wren_q    <= 1'b0;
            mem_datain_q  <= '0;
            a_gnt_q       <= 1'b0;
            b_gnt_q       <= 1'b0;
            a_rvalid_q    <= 1'b0;
            b_rvalid_q    <= 1'b0;
            a_rdata_q     <= '0;
            b_rdata_q     <= '0;
        end else begin
            state_q       <= state_d;
            last_b_q      <= last_b_d;
            owner_b_q     <= owner_b_d;
            cnt_q         <= cnt_d;
            mem_address_q <= mem_address_d;
            mem_wren_q    <= mem_wren_d;
            mem_datain_q  <= mem_datain_d;
            a_gnt_q       <= a_gnt_d;
            b_gnt_q       <= b_gnt_d;
            a_rvalid_q    <= a_rvalid_d;
            b_rvalid_q    <= b_rvalid_d;
            a_rdata_q     <= a_rdata_d;
            b_rdata_q     <= b_rdata_d;
        end
    end

    assign a_gnt       = a_gnt_q;
    assign b_gnt       = b_gnt_q;
    assign a_rvalid    = a_rvalid_q;
    assign b_rvalid    = b_rvalid_q;
    assign a_rdata     = a_rdata_q;
    assign b_rdata     = b_rdata_q;
    assign mem_address = mem_address_q;
    assign mem_wren    = mem_wren_q;
    assign mem_datain  = mem_datain_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Drives dmem_arbiter (RD_LAT = 3) against a simple RAM with configurable
// read latency. Expected behaviour comes from a transaction-level model:
// a pending-request table per requester, a round-robin (or fixed-priority)
// winner choice, a reference memory array and per-requester held rdata.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 3;

    logic              clk;
    logic              reset;
    logic              a_req, a_we, b_req, b_we;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_wdata, b_wdata;
    logic              a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DATA_W-1:0] a_rdata, b_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_datain, mem_dataout;
    logic              busy;

    dmem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .a_req      (a_req),
        .a_we       (a_we),
        .a_addr     (a_addr),
        .a_wdata    (a_wdata),
        .a_gnt      (a_gnt),
        .a_rvalid   (a_rvalid),
        .a_rdata    (a_rdata),
        .b_req      (b_req),
        .b_we       (b_we),
        .b_addr     (b_addr),
        .b_wdata    (b_wdata),
        .b_gnt      (b_gnt),
        .b_rvalid   (b_rvalid),
        .b_rdata    (b_rdata),
        .mem_address(mem_address),
        .mem_wren   (mem_wren),
        .mem_datain (mem_datain),
        .mem_dataout(mem_dataout),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment RAM: address sampled on each edge, output after RD_LAT edges.
    logic [DATA_W-1:0] ram  [128];
    logic [DATA_W-1:0] pipe [RD_LAT];

    always @(posedge clk) begin
        if (mem_wren) ram[mem_address] <= mem_datain;
        pipe[0] <= ram[mem_address];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_dataout = pipe[RD_LAT-1];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference model
    logic [DATA_W-1:0] ref_mem [128];
    logic              last_b;
    logic [DATA_W-1:0] ref_rdata [2];
    bit                pend [2];
    bit                p_we [2];
    logic [ADDR_W-1:0] p_addr [2];
    logic [DATA_W-1:0] p_wdata [2];
    int                grant_log [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        a_req   = pend[0];
        a_we    = p_we[0];
        a_addr  = p_addr[0];
        a_wdata = p_wdata[0];
        b_req   = pend[1];
        b_we    = p_we[1];
        b_addr  = p_addr[1];
        b_wdata = p_wdata[1];
    endtask

    task automatic set_req(input int q, input bit we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata);
        pend[q]    = 1'b1;
        p_we[q]    = we;
        p_addr[q]  = addr;
        p_wdata[q] = wdata;
    endtask

    task automatic model_reset();
        last_b       = 1'b1;
        ref_rdata[0] = '0;
        ref_rdata[1] = '0;
        pend[0]      = 1'b0;
        pend[1]      = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, mem_address, 0);
        check({tag, "_wren"}, mem_wren, 0);
        check({tag, "_din"}, mem_datain, 0);
        check({tag, "_agnt"}, a_gnt, 0);
        check({tag, "_bgnt"}, b_gnt, 0);
        check({tag, "_arv"}, a_rvalid, 0);
        check({tag, "_brv"}, b_rvalid, 0);
        check({tag, "_ard"}, a_rdata, 0);
        check({tag, "_brd"}, b_rdata, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // One arbitration round, entered at #1 into an idle cycle with at least
    // one request pending; leaves at #1 into the next idle cycle.
    task automatic run_round();
        int w;
        logic [DATA_W-1:0] exp;
        drive_reqs();
        if (pend[0] && pend[1]) begin
`ifdef DMEM_ARB_FIXED_PRI_EN
            w = 0;
`else
            w = last_b ? 0 : 1;
`endif
        end else begin
            w = pend[0] ? 0 : 1;
        end
        last_b = (w == 1);
        tick();
        check("a_gnt", a_gnt, (w == 0));
        check("b_gnt", b_gnt, (w == 1));
        check("busy_access", busy, 1);
        check("mem_address", mem_address, p_addr[w]);
        check("mem_wren", mem_wren, p_we[w]);
        if (p_we[w]) check("mem_datain", mem_datain, p_wdata[w]);
        grant_log.push_back(w);
        pend[w] = 1'b0;
        drive_reqs();
        if (p_we[w]) begin
            ref_mem[p_addr[w]] = p_wdata[w];
            tick();
            check("busy_after_wr", busy, 0);
            check("wren_after_wr", mem_wren, 0);
            check("gnt_after_wr", a_gnt | b_gnt, 0);
            check("a_rdata_held_wr", a_rdata, ref_rdata[0]);
            check("b_rdata_held_wr", b_rdata, ref_rdata[1]);
        end else begin
            exp = ref_mem[p_addr[w]];
            for (int k = 0; k < RD_LAT; k++) begin
                tick();
                check("busy_wait", busy, 1);
                check("rvalid_early", a_rvalid | b_rvalid, 0);
                check("addr_hold", mem_address, p_addr[w]);
                check("wren_wait", mem_wren, 0);
                check("gnt_wait", a_gnt | b_gnt, 0);
            end
            tick();
            check("a_rvalid", a_rvalid, (w == 0));
            check("b_rvalid", b_rvalid, (w == 1));
            check(w == 0 ? "a_rdata" : "b_rdata", w == 0 ? a_rdata : b_rdata, exp);
            check(w == 0 ? "b_rdata_kept" : "a_rdata_kept", w == 0 ? b_rdata : a_rdata,
                  ref_rdata[1-w]);
            check("busy_after_rd", busy, 0);
            ref_rdata[w] = exp;
        end
    endtask

    // Invariants checked every cycle outside reset.
    always @(negedge clk) begin
        if (!reset) begin
            check("gnt_exclusive", a_gnt & b_gnt, 0);
            check("wren_outside_access", mem_wren & ~(a_gnt | b_gnt), 0);
        end
    end

    initial begin
        int exp_order [4];
        reset = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        p_we[0] = 1'b0; p_we[1] = 1'b0;
        p_addr[0] = '0; p_addr[1] = '0;
        p_wdata[0] = '0; p_wdata[1] = '0;
        drive_reqs();
        for (int i = 0; i < 128; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;
        model_reset();
        #1 reset = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // Single write from A
        set_req(0, 1'b1, 7'h01, 8'h5A);
        run_round();

        // B write, then simultaneous reads: A wins the tie, then B
        set_req(1, 1'b1, 7'h02, 8'hF0);
        run_round();
        set_req(0, 1'b0, 7'h01, 8'h00);
        set_req(1, 1'b0, 7'h02, 8'h00);
        grant_log.delete();
        run_round();
        run_round();
        check("tie_first", grant_log[0], 0);
        check("tie_second", grant_log[1], 1);
        check("a_rdata_5a", a_rdata, 8'h5A);
        check("b_rdata_f0", b_rdata, 8'hF0);

        // Both requesters held high for four grants
`ifdef DMEM_ARB_FIXED_PRI_EN
        exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 0; exp_order[3] = 0;
`else
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
`endif
        grant_log.delete();
        set_req(0, 1'b1, 7'h10, 8'h11);
        set_req(1, 1'b1, 7'h20, 8'h22);
        for (int r = 0; r < 4; r++) begin
            run_round();
            if (r < 3) begin
                set_req(grant_log[r], 1'b1, p_addr[grant_log[r]] + 7'd1,
                        p_wdata[grant_log[r]] + 8'd1);
            end
        end
        for (int r = 0; r < 4; r++) check($sformatf("order%0d", r), grant_log[r], exp_order[r]);
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        drive_reqs();
        tick();

        // Top address: write then read; the other rdata must not move
        set_req(0, 1'b1, 7'h7F, 8'hAA);
        run_round();
        set_req(0, 1'b0, 7'h7F, 8'h00);
        run_round();
        check("rdata_7f", a_rdata, 8'hAA);
        check("b_rdata_untouched", b_rdata, ref_rdata[1]);

        // Reset while a read waits on memory
        set_req(0, 1'b0, 7'h01, 8'h00);
        drive_reqs();
        last_b = 1'b0;
        tick();
        check("rst_wait_gnt", a_gnt, 1);
        pend[0] = 1'b0;
        drive_reqs();
        tick();
        check("rst_wait_busy", busy, 1);
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        model_reset();
        tick();
        reset = 1'b0;
        for (int k = 0; k < RD_LAT + 2; k++) begin
            tick();
            check("no_rvalid_after_reset", a_rvalid | b_rvalid, 0);
            check("idle_after_reset", busy, 0);
        end
        set_req(0, 1'b0, 7'h01, 8'h00);
        run_round();
        check("post_reset_read", a_rdata, 8'h5A);

        // Randomised traffic
        for (int r = 0; r < 60; r++) begin
            for (int q = 0; q < 2; q++) begin
                if (!pend[q] && $urandom_range(0, 1) == 1) begin
                    set_req(q, 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 4) == 0) ? 7'h7F : 7'($urandom_range(0, 7)),
                            8'($urandom));
                end
            end
            if (!pend[0] && !pend[1]) begin
                drive_reqs();
                tick();
                check("idle_no_gnt", a_gnt | b_gnt, 0);
                check("idle_busy_rand", busy, 0);
            end else begin
                run_round();
            end
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        drive_reqs();
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port 8-bit x 128 data memory.
- Requester A (e.g. CPU load/store) and requester B (e.g. DMA/debug loader) issue read/write requests.
- The arbiter grants one request at a time and drives the memory's address, write-enable and write-data.
- For reads, it waits the memory read latency, then returns read data to the granted requester with a valid pulse.

Parameters:
- ADDR_W, 7, address width; matches memory address[6:0].
- DATA_W, 8, data width; matches memory dataIn/dataOut.
- RD_LAT, 1, cycles from memory address applied to memory dataOut valid; legal range 1..7.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- a_req  input  1  requester A request; held high with fields stable until a_gnt.
- a_we  input  1  A: 1=write, 0=read.
- a_addr  input  ADDR_W  A address.
- a_wdata  input  DATA_W  A write data.
- a_gnt  output  1  one-cycle pulse: A's request accepted.
- a_rvalid  output  1  one-cycle pulse: a_rdata valid.
- a_rdata  output  DATA_W  A read data; held until next A read completes.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as A, for requester B.
- mem_address  output  ADDR_W  to memory address.
- mem_wren  output  1  to memory Wren.
- mem_datain  output  DATA_W  to memory dataIn.
- mem_dataout  input  DATA_W  from memory dataOut.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, active-high; also applies mid-operation):
  - State IDLE; all outputs 0, including mem_address, mem_wren, mem_datain, gnt, rvalid, rdata and busy.
  - last_grant=B, so A wins the first tie.
  - An in-flight read is abandoned; no rvalid is issued.
  - A write whose ACCESS cycle is cut by reset is not guaranteed to land.
- FSM states: IDLE, ACCESS, WAIT.
- IDLE:
  - On an edge with any req high, select the winner.
  - Round-robin: if both requesters are high, grant the one not in last_grant; otherwise grant the single requester.
  - Register the winner's addr/we/wdata into mem_address/mem_wren/mem_datain.
  - Assert that requester's gnt for exactly one cycle, update last_grant, go to ACCESS.
- ACCESS (1 cycle):
  - Memory sees address/wren/datain this cycle.
  - Write: next edge clears mem_wren to 0 and returns to IDLE; the write commits on that edge.
  - Read: mem_wren is 0; load the counter with RD_LAT-1 and go to WAIT.
- WAIT:
  - mem_address is held stable.
  - Decrement the counter each edge.
  - On the edge where the counter is 0, capture mem_dataout into the owner's rdata, pulse the owner's rvalid for one cycle, and go to IDLE.
- Requester rule:
  - Drop req, or present a new request, on the edge ending the gnt cycle.
  - In IDLE, req is sampled only on edges where state==IDLE.
- Timing:
  - Latency from req sampled to gnt: 1 cycle.
  - Write occupancy: 2 cycles (IDLE+ACCESS).
  - Read: rvalid arrives 1+RD_LAT cycles after gnt.
- mem_wren is never high outside ACCESS; at most one gnt is high per cycle.
- The non-granted requester's req is ignored until the next IDLE. A requester held high continuously by both sides alternates A, B, A, B.
- Address and data pass through unmodified; no width conversion. Address wrap is the caller's concern; 7'h7F is legal.
- rdata is held between reads; a write does not disturb rdata.

Optional Feature:
- Macro DMEM_ARB_FIXED_PRI_EN.
- Defined: fixed priority. A always wins when both requesters are high; last_grant is ignored; B can starve.
- Undefined: round-robin as above.
- All timing is identical in both modes.

Test Plan:
- Reset, then a_req write addr 7'h01 data 8'h5A -> a_gnt 1 cycle after req; mem_wren=1 for exactly 1 cycle with mem_address=7'h01, mem_datain=8'h5A; busy falls afterwards.
- b_req write addr 7'h02 data 8'hF0, then a_req read 7'h01 and b_req read 7'h02 (RD_LAT=1) -> a_rdata=8'h5A with a_rvalid; b_rdata=8'hF0 with b_rvalid, each arriving 2 cycles after its gnt.
- a_req and b_req held high together for 4 grants -> grant order A, B, A, B. With DMEM_ARB_FIXED_PRI_EN: A, A, A, A and b_gnt never fires.
- Read issued, reset asserted during WAIT (RD_LAT=3) -> all outputs 0 immediately; no rvalid afterwards; next request after reset is serviced normally.
- Write 7'h7F=8'hAA then read 7'h7F -> rdata=8'hAA; the other requester's rdata is unchanged.
- Throughout all tests: mem_wren never high outside a gnt+0 ACCESS cycle; a_gnt&b_gnt never both high.
